// File: rtl/multi_ported_sram_ctrl_if.sv
// Request/response bus between clients, the controller and the XOR multi-ported SRAM.
// The master side is the requesters plus the SRAM macro; the slave side is the controller.
interface multi_ported_sram_ctrl_if #(
    parameter int NUM_W  = 2,
    parameter int NUM_R  = 2,
    parameter int W      = 32,
    parameter int N      = 8,
    parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
);
    logic                    init;
    logic                    busy;
    logic [NUM_W-1:0]        wr_vld;
    logic [NUM_W*ADDR_W-1:0] wr_addr;
    logic [NUM_W*W-1:0]      wr_data;
    logic [NUM_W-1:0]        wr_rdy;
    logic [NUM_R-1:0]        rd_vld;
    logic [NUM_R*ADDR_W-1:0] rd_addr;
    logic [NUM_R-1:0]        rd_rdy;
    logic [NUM_R-1:0]        rsp_vld;
    logic [NUM_R*W-1:0]      rsp_data;
    logic [NUM_W-1:0]        sram_wen;
    logic [NUM_W*ADDR_W-1:0] sram_waddr;
    logic [NUM_W*W-1:0]      sram_wdata;
    logic [NUM_R-1:0]        sram_ren;
    logic [NUM_R*ADDR_W-1:0] sram_raddr;
    logic [NUM_R*W-1:0]      sram_rdata;

    modport master (
        output init, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, sram_rdata,
        input  busy, wr_rdy, rd_rdy, rsp_vld, rsp_data,
               sram_wen, sram_waddr, sram_wdata, sram_ren, sram_raddr
    );

    modport slave (
        input  init, wr_vld, wr_addr, wr_data, rd_vld, rd_addr, sram_rdata,
        output busy, wr_rdy, rd_rdy, rsp_vld, rsp_data,
               sram_wen, sram_waddr, sram_wdata, sram_ren, sram_raddr
    );
endinterface

// File: rtl/multi_ported_sram_ctrl.sv
// Front-end for the XOR multi-ported SRAM: zero-fills the array after reset or init and
// arbitrates client reads/writes, stalling the hazards the XOR banks cannot resolve.
module multi_ported_sram_ctrl #(
    parameter int NUM_W = 2,
    parameter int NUM_R = 2,
    parameter int W     = 32,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_ported_sram_ctrl_if.slave bus
);
    localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_DRAIN, ST_IDLE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       fill_cnt, fill_cnt_nxt;
    logic [NUM_W-1:0]        hist_vld_p1;
    logic [NUM_W*ADDR_W-1:0] hist_addr_p1;
    logic [NUM_R-1:0]        rsp_vld_p1;

    logic                    idle;
    logic [NUM_W-1:0]        wr_blk, wr_rdy_c, wr_acc;
    logic [NUM_R-1:0]        rd_blk, rd_rdy_c, rd_acc;
    logic [NUM_W-1:0]        sram_wen_c;
    logic [NUM_W*ADDR_W-1:0] sram_waddr_c;
    logic [NUM_W*W-1:0]      sram_wdata_c;

    // p0 -> p1: state, fill counter, one-deep accepted-write history, read response valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_INIT;
            fill_cnt    <= '0;
            hist_vld_p1 <= '0;
            rsp_vld_p1  <= '0;
        end else begin
            state       <= state_nxt;
            fill_cnt    <= fill_cnt_nxt;
            hist_vld_p1 <= (state == ST_IDLE && bus.init) ? '0 : wr_acc;
            rsp_vld_p1  <= rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        hist_addr_p1 <= bus.wr_addr;
    end

    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        unique case (state)
            ST_INIT: begin
                fill_cnt_nxt = fill_cnt + ADDR_W'(1);
                if (fill_cnt == ADDR_W'(N - 1)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (bus.init) begin
                    state_nxt    = ST_INIT;
                    fill_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        idle   = (state == ST_IDLE);
        wr_blk = '0;
        rd_blk = '0;
        // A write loses to a lower-index port on the same address, and to a different
        // port that wrote the same address last cycle (its bank read would be stale).
        for (int p = 0; p < NUM_W; p++) begin
            for (int q = 0; q < NUM_W; q++) begin
                if (q < p && bus.wr_vld[q] &&
                    bus.wr_addr[q*ADDR_W +: ADDR_W] == bus.wr_addr[p*ADDR_W +: ADDR_W]) begin
                    wr_blk[p] = 1'b1;
                end
                if (q != p && hist_vld_p1[q] &&
                    hist_addr_p1[q*ADDR_W +: ADDR_W] == bus.wr_addr[p*ADDR_W +: ADDR_W]) begin
                    wr_blk[p] = 1'b1;
                end
            end
        end
        for (int r = 0; r < NUM_R; r++) begin
            for (int p = 0; p < NUM_W; p++) begin
                if (hist_vld_p1[p] &&
                    hist_addr_p1[p*ADDR_W +: ADDR_W] == bus.rd_addr[r*ADDR_W +: ADDR_W]) begin
                    rd_blk[r] = 1'b1;
                end
                if (bus.wr_vld[p] &&
                    bus.wr_addr[p*ADDR_W +: ADDR_W] == bus.rd_addr[r*ADDR_W +: ADDR_W]) begin
                    rd_blk[r] = 1'b1;
                end
            end
        end
        wr_rdy_c = idle ? ~wr_blk : '0;
        rd_rdy_c = idle ? ~rd_blk : '0;
        wr_acc   = bus.wr_vld & wr_rdy_c;
        rd_acc   = bus.rd_vld & rd_rdy_c;

        sram_wen_c   = wr_acc;
        sram_waddr_c = bus.wr_addr;
        sram_wdata_c = bus.wr_data;
        if (state == ST_INIT) begin
            sram_wen_c[0]              = 1'b1;
            sram_waddr_c[ADDR_W-1:0]   = fill_cnt;
            sram_wdata_c[W-1:0]        = '0;
        end
    end

    assign bus.busy       = ~idle;
    assign bus.wr_rdy     = wr_rdy_c;
    assign bus.rd_rdy     = rd_rdy_c;
    assign bus.sram_wen   = sram_wen_c;
    assign bus.sram_waddr = sram_waddr_c;
    assign bus.sram_wdata = sram_wdata_c;
    assign bus.sram_ren   = rd_acc;
    assign bus.sram_raddr = bus.rd_addr;
    assign bus.rsp_vld    = rsp_vld_p1;
    assign bus.rsp_data   = bus.sram_rdata;
endmodule
